decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_pkg.sv | 42 ++++
 rtl/decode_fields.sv | 84 ++++++++
 rtl/decode_stage.sv | 137 +++++++++++++
 tb/tb_decode_stage.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared decode definitions: opcode[6:2] classes, out_fmt bit
// positions and the decoded payload carried between stages.
package decode_pkg;

    localparam logic [4:0] OP_LOAD      = 5'b00000;
    localparam logic [4:0] OP_LOAD_FP   = 5'b00001;
    localparam logic [4:0] OP_MISC_MEM  = 5'b00011;
    localparam logic [4:0] OP_OP_IMM    = 5'b00100;
    localparam logic [4:0] OP_AUIPC     = 5'b00101;
    localparam logic [4:0] OP_OP_IMM_32 = 5'b00110;
    localparam logic [4:0] OP_STORE     = 5'b01000;
    localparam logic [4:0] OP_STORE_FP  = 5'b01001;
    localparam logic [4:0] OP_AMO       = 5'b01011;
    localparam logic [4:0] OP_OP        = 5'b01100;
    localparam logic [4:0] OP_LUI       = 5'b01101;
    localparam logic [4:0] OP_OP_32     = 5'b01110;
    localparam logic [4:0] OP_OP_FP     = 5'b10100;
    localparam logic [4:0] OP_BRANCH    = 5'b11000;
    localparam logic [4:0] OP_JALR      = 5'b11001;
    localparam logic [4:0] OP_JAL       = 5'b11011;
    localparam logic [4:0] OP_SYSTEM    = 5'b11100;

    localparam int FMT_R = 0;
    localparam int FMT_I = 1;
    localparam int FMT_S = 2;
    localparam int FMT_B = 3;
    localparam int FMT_U = 4;
    localparam int FMT_J = 5;

    typedef struct packed {
        logic       illegal;
        logic [5:0] fmt;
        logic       imm_valid;
        logic [6:0] opcode;
        logic [2:0] funct3;
        logic [6:0] funct7;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
    } dec_t;

endpackage

// File: rtl/decode_fields.sv
// Combinational RV32/RV64 field extractor: format class, register
// indices, sign-extended immediate and illegal-instruction flag.
module decode_fields
    import decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     i_instr,
    output dec_t            o_dec,
    output logic [XLEN-1:0] o_imm
);

    logic [4:0]         w_op;
    logic [5:0]         w_cls;
    logic               w_rv64_only;
    logic               w_illegal;
    logic signed [31:0] w_imm32;

    assign w_op = i_instr[6:2];

    assign w_cls[FMT_R] = w_op inside {OP_AMO, OP_OP, OP_OP_32, OP_OP_FP};
    assign w_cls[FMT_I] = w_op inside {OP_LOAD, OP_LOAD_FP, OP_MISC_MEM,
                                       OP_OP_IMM, OP_OP_IMM_32, OP_JALR,
                                       OP_SYSTEM};
    assign w_cls[FMT_S] = w_op inside {OP_STORE, OP_STORE_FP};
    assign w_cls[FMT_B] = (w_op == OP_BRANCH);
    assign w_cls[FMT_U] = w_op inside {OP_AUIPC, OP_LUI};
    assign w_cls[FMT_J] = (w_op == OP_JAL);

    assign w_rv64_only = (w_op == OP_OP_IMM_32) || (w_op == OP_OP_32);

    assign w_illegal = (i_instr[1:0] != 2'b11)
                    || (w_cls == '0)
                    || ((XLEN == 32) && w_rv64_only);

    always_comb begin
        o_dec   = '0;
        w_imm32 = '0;
        o_dec.illegal = w_illegal;
        if (!w_illegal) begin
            o_dec.fmt       = w_cls;
            o_dec.imm_valid = !w_cls[FMT_R];
            o_dec.opcode    = i_instr[6:0];
            o_dec.funct3    = i_instr[14:12];
            o_dec.funct7    = i_instr[31:25];
            o_dec.rs1       = i_instr[19:15];
            o_dec.rs2       = i_instr[24:20];
            o_dec.rd        = i_instr[11:7];
            unique case (1'b1)
                w_cls[FMT_I]: begin
                    o_dec.rs2 = '0;
                    w_imm32   = {{20{i_instr[31]}}, i_instr[31:20]};
                end
                w_cls[FMT_S]: begin
                    o_dec.funct7 = '0;
                    o_dec.rd     = '0;
                    w_imm32      = {{20{i_instr[31]}}, i_instr[31:25],
                                    i_instr[11:7]};
                end
                w_cls[FMT_B]: begin
                    o_dec.funct7 = '0;
                    o_dec.rd     = '0;
                    w_imm32      = {{20{i_instr[31]}}, i_instr[7],
                                    i_instr[30:25], i_instr[11:8], 1'b0};
                end
                w_cls[FMT_U], w_cls[FMT_J]: begin
                    o_dec.funct3 = '0;
                    o_dec.rs1    = '0;
                    o_dec.rs2    = '0;
                    o_dec.funct7 = '0;
                    if (w_cls[FMT_U])
                        w_imm32 = {i_instr[31:12], 12'b0};
                    else
                        w_imm32 = {{12{i_instr[31]}}, i_instr[19:12],
                                   i_instr[20], i_instr[30:21], 1'b0};
                end
                default: ;
            endcase
        end
    end

    assign o_imm = XLEN'(w_imm32);

endmodule

// File: rtl/decode_stage.sv
// Decode pipeline stage with valid/ready handshake and illegal counter.
// DECODE_SKID_EN adds a one-entry skid buffer with registered in_ready.
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [6:0]       out_opcode,
    output logic [2:0]       out_funct3,
    output logic [6:0]       out_funct7,
    output logic [4:0]       out_rs1,
    output logic [4:0]       out_rs2,
    output logic [4:0]       out_rd,
    output logic [XLEN-1:0]  out_imm,
    output logic             out_imm_valid,
    output logic [5:0]       out_fmt,
    output logic             out_illegal,
    output logic [CNT_W-1:0] illegal_cnt
);

    dec_t             w_dec;
    logic [XLEN-1:0]  w_imm;
    logic             w_acc;
    logic             r_out_valid;
    dec_t             r_out_dec;
    logic [XLEN-1:0]  r_out_imm;
    logic [XLEN-1:0]  r_out_pc;
    logic [CNT_W-1:0] r_cnt;

    decode_fields #(.XLEN(XLEN)) u_fields (
        .i_instr (in_instr),
        .o_dec   (w_dec),
        .o_imm   (w_imm)
    );

`ifdef DECODE_SKID_EN
    logic             r_skid_valid;
    dec_t             r_skid_dec;
    logic [XLEN-1:0]  r_skid_imm;
    logic [XLEN-1:0]  r_skid_pc;

    assign in_ready = !r_skid_valid;
    assign w_acc    = in_valid && !r_skid_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_dec    <= '0;
            r_out_imm    <= '0;
            r_out_pc     <= '0;
            r_skid_valid <= 1'b0;
            r_skid_dec   <= '0;
            r_skid_imm   <= '0;
            r_skid_pc    <= '0;
        end else if (flush) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (!r_out_valid || out_ready) begin
            // skid never coexists with an accept: in_ready is low then
            if (r_skid_valid) begin
                r_out_valid  <= 1'b1;
                r_out_dec    <= r_skid_dec;
                r_out_imm    <= r_skid_imm;
                r_out_pc     <= r_skid_pc;
                r_skid_valid <= 1'b0;
            end else if (w_acc) begin
                r_out_valid <= 1'b1;
                r_out_dec   <= w_dec;
                r_out_imm   <= w_imm;
                r_out_pc    <= in_pc;
            end else begin
                r_out_valid <= 1'b0;
            end
        end else if (w_acc) begin
            r_skid_valid <= 1'b1;
            r_skid_dec   <= w_dec;
            r_skid_imm   <= w_imm;
            r_skid_pc    <= in_pc;
        end
    end
`else
    assign in_ready = !r_out_valid || out_ready;
    assign w_acc    = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_dec   <= '0;
            r_out_imm   <= '0;
            r_out_pc    <= '0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_acc) begin
            r_out_valid <= 1'b1;
            r_out_dec   <= w_dec;
            r_out_imm   <= w_imm;
            r_out_pc    <= in_pc;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end
`endif

    // counted at acceptance; a flushed accept is discarded uncounted
    always_ff @(posedge clk) begin
        if (rst)
            r_cnt <= '0;
        else if (!flush && w_acc && w_dec.illegal && (r_cnt != '1))
            r_cnt <= r_cnt + CNT_W'(1);
    end

    assign out_valid     = r_out_valid;
    assign out_pc        = r_out_pc;
    assign out_opcode    = r_out_dec.opcode;
    assign out_funct3    = r_out_dec.funct3;
    assign out_funct7    = r_out_dec.funct7;
    assign out_rs1       = r_out_dec.rs1;
    assign out_rs2       = r_out_dec.rs2;
    assign out_rd        = r_out_dec.rd;
    assign out_imm       = r_out_imm;
    assign out_imm_valid = r_out_dec.imm_valid;
    assign out_fmt       = r_out_dec.fmt;
    assign out_illegal   = r_out_dec.illegal;
    assign illegal_cnt   = r_cnt;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: an RV32 instance (CNT_W=4) and an RV64
// instance share stimulus; a FIFO reference model predicts both.
module tb_decode_stage;

`ifdef DECODE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_instr;
    logic [63:0] in_pc;

    logic        a_in_ready, a_out_valid, a_out_imm_valid, a_out_illegal;
    logic [31:0] a_out_pc, a_out_imm;
    logic [6:0]  a_out_opcode, a_out_funct7;
    logic [2:0]  a_out_funct3;
    logic [4:0]  a_out_rs1, a_out_rs2, a_out_rd;
    logic [5:0]  a_out_fmt;
    logic [3:0]  a_cnt;

    logic        b_in_ready, b_out_valid, b_out_imm_valid, b_out_illegal;
    logic [63:0] b_out_pc, b_out_imm;
    logic [6:0]  b_out_opcode, b_out_funct7;
    logic [2:0]  b_out_funct3;
    logic [4:0]  b_out_rs1, b_out_rs2, b_out_rd;
    logic [5:0]  b_out_fmt;
    logic [15:0] b_cnt;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(32), .CNT_W(4)) u_a (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(a_in_ready),
        .in_instr(in_instr), .in_pc(in_pc[31:0]),
        .out_valid(a_out_valid), .out_ready(out_ready),
        .out_pc(a_out_pc), .out_opcode(a_out_opcode),
        .out_funct3(a_out_funct3), .out_funct7(a_out_funct7),
        .out_rs1(a_out_rs1), .out_rs2(a_out_rs2), .out_rd(a_out_rd),
        .out_imm(a_out_imm), .out_imm_valid(a_out_imm_valid),
        .out_fmt(a_out_fmt), .out_illegal(a_out_illegal),
        .illegal_cnt(a_cnt)
    );

    decode_stage #(.XLEN(64), .CNT_W(16)) u_b (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(b_in_ready),
        .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(b_out_valid), .out_ready(out_ready),
        .out_pc(b_out_pc), .out_opcode(b_out_opcode),
        .out_funct3(b_out_funct3), .out_funct7(b_out_funct7),
        .out_rs1(b_out_rs1), .out_rs2(b_out_rs2), .out_rd(b_out_rd),
        .out_imm(b_out_imm), .out_imm_valid(b_out_imm_valid),
        .out_fmt(b_out_fmt), .out_illegal(b_out_illegal),
        .illegal_cnt(b_cnt)
    );

    typedef struct packed {
        logic        illegal;
        logic [5:0]  fmt;
        logic        immv;
        logic [6:0]  opcode;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [63:0] imm;
    } exp_t;

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
    } ent_t;

    ent_t q[$];
    int   m_cnt_a, m_cnt_b;
    int   ncmp = 0;
    int   nfail = 0;
    bit   chk_en = 1'b0;
    bit   last_acc = 1'b0;

    // Decoding straight from the instruction-set format rules.
    function automatic exp_t ref_dec(input logic [31:0] w, input int xlen);
        exp_t        e;
        int          k;
        logic [63:0] imm;
        e   = '0;
        imm = '0;
        case (w[6:2])
            5'b01011, 5'b01100, 5'b01110, 5'b10100:          k = 0;
            5'b00000, 5'b00001, 5'b00011, 5'b00100,
            5'b00110, 5'b11001, 5'b11100:                    k = 1;
            5'b01000, 5'b01001:                              k = 2;
            5'b11000:                                        k = 3;
            5'b00101, 5'b01101:                              k = 4;
            5'b11011:                                        k = 5;
            default:                                         k = -1;
        endcase
        if (w[1:0] != 2'b11) k = -1;
        if (xlen == 32 && (w[6:2] == 5'b00110 || w[6:2] == 5'b01110)) k = -1;
        if (k < 0) begin
            e.illegal = 1'b1;
            return e;
        end
        e.fmt    = 6'(1 << k);
        e.immv   = (k != 0);
        e.opcode = w[6:0];
        e.f3     = w[14:12];
        e.f7     = w[31:25];
        e.rs1    = w[19:15];
        e.rs2    = w[24:20];
        e.rd     = w[11:7];
        case (k)
            1: begin
                imm   = longint'($signed(w[31:20]));
                e.rs2 = 0;
            end
            2: begin
                imm  = longint'($signed({w[31:25], w[11:7]}));
                e.f7 = 0;
                e.rd = 0;
            end
            3: begin
                imm  = longint'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
                e.f7 = 0;
                e.rd = 0;
            end
            4, 5: begin
                if (k == 4) imm = longint'($signed({w[31:12], 12'h000}));
                else imm = longint'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0}));
                e.f3  = 0;
                e.rs1 = 0;
                e.rs2 = 0;
                e.f7  = 0;
            end
            default: imm = 0;
        endcase
        e.imm = (xlen == 32) ? {32'h0, imm[31:0]} : imm;
        return e;
    endfunction

    function automatic logic [39:0] pk(input exp_t e);
        return {e.illegal, e.fmt, e.immv, e.opcode, e.f3, e.f7, e.rs1, e.rs2, e.rd};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Check outputs against the model, then advance one clock.
    task automatic cycle();
        bit   exp_ir, acc;
        ent_t h;
        exp_t ea, eb;
        #1;
        exp_ir = SKID ? (q.size() < 2) : (q.size() == 0 || out_ready);
        if (chk_en) begin
            chk("in_ready_a", a_in_ready, exp_ir);
            chk("in_ready_b", b_in_ready, exp_ir);
            chk("out_valid_a", a_out_valid, q.size() != 0);
            chk("out_valid_b", b_out_valid, q.size() != 0);
            chk("cnt_a", a_cnt, m_cnt_a);
            chk("cnt_b", b_cnt, m_cnt_b);
            if (q.size() != 0) begin
                h  = q[0];
                ea = ref_dec(h.instr, 32);
                eb = ref_dec(h.instr, 64);
                chk("fields_a", {a_out_illegal, a_out_fmt, a_out_imm_valid,
                    a_out_opcode, a_out_funct3, a_out_funct7, a_out_rs1,
                    a_out_rs2, a_out_rd}, pk(ea));
                chk("fields_b", {b_out_illegal, b_out_fmt, b_out_imm_valid,
                    b_out_opcode, b_out_funct3, b_out_funct7, b_out_rs1,
                    b_out_rs2, b_out_rd}, pk(eb));
                chk("imm_a", a_out_imm, ea.imm);
                chk("imm_b", b_out_imm, eb.imm);
                chk("pc_a", a_out_pc, h.pc[31:0]);
                chk("pc_b", b_out_pc, h.pc);
            end
        end
        acc = in_valid && exp_ir;
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_cnt_a = 0;
            m_cnt_b = 0;
        end else if (flush) begin
            q.delete();
        end else begin
            if (q.size() != 0 && out_ready) void'(q.pop_front());
            if (acc) begin
                q.push_back('{instr: in_instr, pc: in_pc});
                ea = ref_dec(in_instr, 32);
                eb = ref_dec(in_instr, 64);
                if (ea.illegal && m_cnt_a < 15) m_cnt_a++;
                if (eb.illegal && m_cnt_b < 65535) m_cnt_b++;
            end
        end
        last_acc = acc;
        @(negedge clk);
    endtask

    task automatic send(input logic [31:0] ins, input logic [63:0] pc);
        in_valid = 1'b1;
        in_instr = ins;
        in_pc    = pc;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (last_acc) break;
        end
        chk("send_accepted", last_acc, 1);
        in_valid = 1'b0;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w      = $urandom;
        w[6:2] = 5'($urandom_range(0, 31));
        if ($urandom_range(0, 9) != 0) w[1:0] = 2'b11;
        return w;
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int sv_a;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_pc = '0;
        m_cnt_a = 0; m_cnt_b = 0;
        @(negedge clk);
        cycle();
        chk_en = 1'b1;
        cycle();
        chk("rst_pc_b", b_out_pc, 0);
        chk("rst_imm_b", b_out_imm, 0);
        chk("rst_fields_b", {b_out_illegal, b_out_fmt, b_out_imm_valid,
            b_out_opcode, b_out_rs1, b_out_rd}, 0);
        rst = 1'b0;
        cycle();
        chk("ready_after_rst", a_in_ready, 1);

        out_ready = 1'b1;
        send(32'hFFF1_0093, 64'h1000);
        chk("addi_valid", b_out_valid, 1);
        chk("addi_rd", b_out_rd, 1);
        chk("addi_rs1", b_out_rs1, 2);
        chk("addi_imm64", b_out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("addi_imm32", a_out_imm, 32'hFFFF_FFFF);
        chk("addi_fmt", b_out_fmt, 6'b000010);
        chk("addi_immv", b_out_imm_valid, 1);

        send(32'h0010_809B, 64'h1004);
        chk("addiw_ill32", a_out_illegal, 1);
        chk("addiw_fmt32", a_out_fmt, 0);
        chk("addiw_cnt32", a_cnt, 1);
        chk("addiw_ill64", b_out_illegal, 0);

        send(32'h0000_4501, 64'h1234_5678_9ABC_DEF0);
        chk("c_ill64", b_out_illegal, 1);
        chk("c_pc64", b_out_pc, 64'h1234_5678_9ABC_DEF0);
        chk("c_pc32", a_out_pc, 32'h9ABC_DEF0);
        cycle();

        // downstream stalled for three cycles while two are offered
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h0020_80B3;
        in_pc     = 64'h2000;
        cycle();
        in_instr  = 32'h0011_2223;
        in_pc     = 64'h2004;
        cycle();
        if (last_acc) in_valid = 1'b0;
        cycle();
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            cycle();
            if (last_acc) in_valid = 1'b0;
        end

        // flush with a new (illegal) instruction accepted alongside
        out_ready = 1'b0;
        send(32'h00A0_0513, 64'h3000);
        sv_a      = m_cnt_a;
        flush     = 1'b1;
        in_valid  = 1'b1;
        in_instr  = 32'h0000_0000;
        in_pc     = 64'h3004;
        out_ready = 1'b1;
        cycle();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_valid", a_out_valid, 0);
        chk("flush_cnt", a_cnt, sv_a);
        cycle();
        cycle();

        // saturation of the 4-bit counter
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++)
            send(32'hFFFF_FFFF, 64'h4000 + 64'(4 * i));
        chk("sat_cnt32", a_cnt, 4'hF);
        chk("sat_cnt64", b_cnt, 17);
        cycle();

        for (int i = 0; i < 600; i++) begin
            rst       = ($urandom_range(0, 99) == 0);
            flush     = ($urandom_range(0, 29) == 0);
            out_ready = ($urandom_range(0, 9) < 6);
            if (!in_valid || last_acc) begin
                in_valid = ($urandom_range(0, 9) < 7);
                in_instr = rand_instr();
                in_pc    = {$urandom, $urandom};
            end
            cycle();
        end
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        cycle();
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
